// File: rtl/ksa_swap_loop_if.sv
// ksa_swap_loop_if: start/key handshake and S-RAM port between the KSA swap loop and its environment
interface ksa_swap_loop_if;
  logic        start_flag;
  logic [23:0] secret_key;
  logic [7:0]  q;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wren;
  logic        done_flag;
  modport master (input start_flag, secret_key, q, output address, data, wren, done_flag);
  modport slave  (output start_flag, secret_key, q, input address, data, wren, done_flag);
endinterface

// File: rtl/ksa_swap_loop.sv
// ksa_swap_loop: RC4 key-scheduling swap loop over a 256x8 synchronous S-RAM
module ksa_swap_loop (
  input logic clk,
  input logic reset_n,
  ksa_swap_loop_if.master bus
);
  typedef enum logic [3:0] {IDLE, RD_I, WT_I, LD_I, RD_J, WT_J, LD_J, WR_I, WR_J, DONE} state_t;
  state_t state;
  logic [7:0] i, j, si, sj, k, j_new, address, data;
  logic [1:0] kidx;
  logic wren, done_flag;
  always_comb k = kidx == 2'd0 ? bus.secret_key[23:16] : kidx == 2'd1 ? bus.secret_key[15:8] : bus.secret_key[7:0];
  assign j_new = j + bus.q + k;
  assign bus.address = address;
  assign bus.data = data;
  assign bus.wren = wren;
  assign bus.done_flag = done_flag;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      kidx <= '0;
      si <= '0;
      sj <= '0;
      address <= '0;
      data <= '0;
      wren <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start_flag) begin
          state <= RD_I;
          i <= '0;
          j <= '0;
          kidx <= '0;
          address <= '0;
          wren <= 1'b0;
        end
        RD_I: state <= WT_I;
        WT_I: state <= LD_I;
        LD_I: begin
          si <= bus.q;
          j <= j_new;
          address <= j_new;
          state <= RD_J;
        end
        RD_J: state <= WT_J;
        WT_J: state <= LD_J;
        LD_J: begin
          sj <= bus.q;
          address <= i;
          data <= bus.q;
          wren <= 1'b1;
          state <= WR_I;
        end
        WR_I: begin
          address <= j;
          data <= si;
          state <= WR_J;
        end
        WR_J: begin
          wren <= 1'b0;
          if (i == 8'hff) begin
            done_flag <= 1'b1;
            state <= DONE;
          end else begin
            i <= i + 8'd1;
            kidx <= kidx == 2'd2 ? 2'd0 : kidx + 2'd1;
            address <= i + 8'd1;
            state <= RD_I;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ksa_swap_loop.sv
// tb_ksa_swap_loop: randomized KSA runs against a behavioural RC4 key-schedule model with an S-RAM model
module tb_ksa_swap_loop;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  ksa_swap_loop_if bus();
  ksa_swap_loop dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic preload = 1'b0;
  always @(posedge clk) begin
    if (preload) for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
    else if (bus.wren) mem[bus.address] <= bus.data;
    bus.q <= mem[bus.address];
  end

  logic [7:0] exp_addr [2048];
  logic [7:0] exp_data [2048];
  logic       exp_wren [2048];
  logic [7:0] exp_s [256];
  int jl [256];
  int tests = 0, fails = 0, n = 0, wr_cnt = 0;
  logic active = 1'b0, idle_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, n, act, exp);
    end
  endtask

  // RC4 KSA on a plain array; each iteration yields the eight per-cycle outputs it must produce
  function automatic void build(input logic [23:0] key);
    int s [256];
    int j = 0;
    for (int a = 0; a < 256; a++) s[a] = a;
    for (int i = 0; i < 256; i++) begin
      int si, sj, b;
      j = (j + s[i] + int'(key[23 - 8 * (i % 3) -: 8])) % 256;
      jl[i] = j;
      si = s[i];
      sj = s[j];
      b = 8 * i;
      for (int t = 0; t < 8; t++) begin
        exp_addr[b + t] = 8'((t < 3 || t == 6) ? i : j);
        exp_wren[b + t] = (t >= 6);
        exp_data[b + t] = 8'(t == 6 ? sj : si);
      end
      s[i] = sj;
      s[j] = si;
    end
    for (int a = 0; a < 256; a++) exp_s[a] = 8'(s[a]);
  endfunction

  always @(negedge clk) begin
    if (active) begin
      if (n < 2048) begin
        chk("address", bus.address, exp_addr[n]);
        chk("wren", bus.wren, exp_wren[n]);
        if (exp_wren[n]) chk("data", bus.data, exp_data[n]);
        chk("done_flag_low", bus.done_flag, 0);
      end else begin
        chk("wren_in_done", bus.wren, 0);
        chk("done_flag_high", bus.done_flag, 1);
      end
      if (bus.wren) wr_cnt++;
      n++;
    end
    if (idle_chk) begin
      chk("idle_wren", bus.wren, 0);
      chk("idle_address", bus.address, 0);
      chk("idle_done", bus.done_flag, 0);
    end
  end

  task automatic run(input logic [23:0] key, input int abort_at, input bit pin_swap);
    int bad = 0;
    build(key);
    @(negedge clk);
    reset_n = 1'b0;
    preload = 1'b1;
    bus.start_flag = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    bus.secret_key = key;
    bus.start_flag = 1'b1;
    n = 0;
    wr_cnt = 0;
    @(posedge clk);
    active = 1'b1;
    if (abort_at >= 0) begin
      repeat (abort_at) @(posedge clk);
      #2;
      active = 1'b0;
      chk("wren_before_reset", bus.wren, 1);
      reset_n = 1'b0;
      #1;
      chk("wren_async_reset", bus.wren, 0);
      chk("done_async_reset", bus.done_flag, 0);
      chk("address_async_reset", bus.address, 0);
      @(negedge clk);
      reset_n = 1'b1;
    end else begin
      for (int c = 0; c < 2148; c++) begin
        @(negedge clk);
        if (c >= 1) bus.start_flag = 1'($urandom);
        if (c >= 2049) bus.secret_key = 24'($urandom);
        if (pin_swap && c == 16) begin
          chk("S1_after_iter1", mem[1], 3);
          chk("S3_after_iter1", mem[3], 1);
        end
      end
      active = 1'b0;
      chk("wren_total", wr_cnt, 512);
      for (int a = 0; a < 256; a++) if (mem[a] !== exp_s[a]) bad++;
      chk("final_S_mismatches", bad, 0);
    end
  endtask

  initial begin
    bus.start_flag = 1'b0;
    bus.secret_key = '0;
    repeat (2) @(negedge clk);
    chk("reset_address", bus.address, 0);
    chk("reset_data", bus.data, 0);
    chk("reset_wren", bus.wren, 0);
    chk("reset_done", bus.done_flag, 0);
    reset_n = 1'b1;
    idle_chk = 1'b1;
    repeat (1000) @(negedge clk);
    idle_chk = 1'b0;
    build(24'h000000);
    chk("model_j0_key0", jl[0], 0);
    chk("model_j1_key0", jl[1], 1);
    chk("model_j2_key0", jl[2], 3);
    chk("model_j3_key0", jl[3], 5);
    chk("model_j4_key0", jl[4], 9);
    build(24'h000249);
    chk("model_j0_key249", jl[0], 0);
    chk("model_j1_key249", jl[1], 3);
    run(24'h000000, -1, 1'b0);
    run(24'h000249, -1, 1'b1);
    run(24'($urandom), 806, 1'b0);
    run(24'($urandom), -1, 1'b0);
    run(24'($urandom), -1, 1'b0);
    run(24'($urandom), -1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
